// File: rtl/grf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the hard-wired zero register index and the pending-write counter type.
package grf_pkg;

    localparam int GRF_DW       = 32;
    localparam int GRF_AW       = 5;
    localparam int GRF_CW       = 2;
    localparam int GRF_ZERO_REG = 0;

    typedef logic [GRF_CW-1:0] cnt_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, incremented
// by accepted issues and decremented by retiring write-backs. Busy lookup
// follows GRF_BYPASS_EN (next-state view when defined).
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int AW    = GRF_AW,
    parameter int CW    = GRF_CW,
    parameter int NREAD = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               issue_en,
    input  logic [AW-1:0]      issue_reg,
    input  logic               we0,
    input  logic [AW-1:0]      wa0,
    input  logic               wr0,
    input  logic               we1,
    input  logic [AW-1:0]      wa1,
    input  logic               wr1,
    input  logic [NREAD*AW-1:0] ra,
    output logic [NREAD-1:0]   rbusy,
    output logic               issue_full
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] ZERO_A   = AW'(GRF_ZERO_REG);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW+1:0] ZERO_W   = {(CW+2){1'b0}};
    localparam logic [CW+1:0] ONE_W    = {{(CW+1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r     [DEPTH];
    logic [CW-1:0] cnt_nxt_s [DEPTH];
    logic [CW+1:0] sum_s     [DEPTH];
    logic [CW+1:0] dec_s     [DEPTH];
    logic [CW+1:0] diff_s    [DEPTH];
    logic          ret0_s;
    logic          ret1_s;
    logic          full_s;
    logic          inc_s;
    logic [NREAD-1:0] rbusy_s;

    // Retires only count for real writes to a non-zero register.
    always_comb begin
        ret0_s = we0 & wr0 & (wa0 != ZERO_A);
        ret1_s = we1 & wr1 & (wa1 != ZERO_A);
    end

    // Per-register retire count for this cycle (0..2).
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            dec_s[r] = (((ret0_s && (wa0 == AW'(r))) ? ONE_W : ZERO_W)
                      + ((ret1_s && (wa1 == AW'(r))) ? ONE_W : ZERO_W));
        end
    end

    // A full counter only rejects the issue if nothing retires it this cycle.
    always_comb begin
        full_s = 1'b0;
        if (issue_reg == ZERO_A) begin
            full_s = 1'b0;
        end else if ((cnt_r[issue_reg] == CNT_MAX) && (dec_s[issue_reg] == ZERO_W)) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        inc_s = issue_en & (issue_reg != ZERO_A) & ~full_s;
    end

    // Next count = cnt + inc - dec, clamped at zero on underflow.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            sum_s[r] = {2'b00, cnt_r[r]} + ((inc_s && (issue_reg == AW'(r))) ? ONE_W : ZERO_W);
            if (sum_s[r] >= dec_s[r]) begin
                diff_s[r] = sum_s[r] - dec_s[r];
            end else begin
                diff_s[r] = ZERO_W;
            end
            cnt_nxt_s[r] = diff_s[r][CW-1:0];
        end
    end

    // Counter state; reset discards any concurrent issue or retire.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

    // Busy lookup per read port.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
`ifdef GRF_BYPASS_EN
            rbusy_s[i] = ({2'b00, cnt_r[ra[i*AW +: AW]]} > dec_s[ra[i*AW +: AW]]);
`else
            rbusy_s[i] = (cnt_r[ra[i*AW +: AW]] != CNT_ZERO);
`endif
        end
    end

    assign rbusy      = rbusy_s;
    assign issue_full = full_s;

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file: two write ports, NREAD read ports and a
// pending-write scoreboard. Write-through forwarding enabled by GRF_BYPASS_EN.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW    = GRF_DW,
    parameter int AW    = GRF_AW,
    parameter int NREAD = 2,
    parameter int CW    = GRF_CW
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NREAD*AW-1:0] RA,
    output logic [NREAD*DW-1:0] RD,
    output logic [NREAD-1:0]    RBusy,
    input  logic                WE0,
    input  logic [AW-1:0]       WA0,
    input  logic [DW-1:0]       WD0,
    input  logic                WR0,
    input  logic                WE1,
    input  logic [AW-1:0]       WA1,
    input  logic [DW-1:0]       WD1,
    input  logic                WR1,
    input  logic                IssueEn,
    input  logic [AW-1:0]       IssueReg,
    output logic                IssueFull
);

    localparam int            DEPTH  = 1 << AW;
    localparam logic [AW-1:0] ZERO_A = AW'(GRF_ZERO_REG);
    localparam logic [DW-1:0] ZERO_D = {DW{1'b0}};

    logic [DW-1:0]       mem_r [DEPTH];
    logic [NREAD*DW-1:0] rd_s;

    // Storage array; port 1 is applied last so it wins an address collision.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= ZERO_D;
            end
        end else begin
            if (WE0 && (WA0 != ZERO_A)) begin
                mem_r[WA0] <= WD0;
            end
            if (WE1 && (WA1 != ZERO_A)) begin
                mem_r[WA1] <= WD1;
            end
        end
    end

    // Read muxes, with optional same-cycle forwarding of in-flight writes.
    always_comb begin
        rd_s = {(NREAD*DW){1'b0}};
        for (int i = 0; i < NREAD; i++) begin
            if (RA[i*AW +: AW] == ZERO_A) begin
                rd_s[i*DW +: DW] = ZERO_D;
`ifdef GRF_BYPASS_EN
            end else if (WE1 && (WA1 == RA[i*AW +: AW])) begin
                rd_s[i*DW +: DW] = WD1;
            end else if (WE0 && (WA0 == RA[i*AW +: AW])) begin
                rd_s[i*DW +: DW] = WD0;
`endif
            end else begin
                rd_s[i*DW +: DW] = mem_r[RA[i*AW +: AW]];
            end
        end
    end

    assign RD = rd_s;

    grf_scoreboard #(
        .AW    (AW),
        .CW    (CW),
        .NREAD (NREAD)
    ) u_sb (
        .Clk        (Clk),
        .Reset      (Reset),
        .issue_en   (IssueEn),
        .issue_reg  (IssueReg),
        .we0        (WE0),
        .wa0        (WA0),
        .wr0        (WR0),
        .we1        (WE1),
        .wa1        (WA1),
        .wr1        (WR1),
        .ra         (RA),
        .rbusy      (RBusy),
        .issue_full (IssueFull)
    );

endmodule
